// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Bit-serial two's-complement subtractor. Computes a - b one bit
//            per clock, LSB first, using a single full-adder cell fed with
//            a and ~b plus a carry flip-flop preset to 1 (the +1 of the
//            negation). Reports the WIDTH-bit difference, a borrow flag and
//            a one-cycle done pulse.
// Ports    : clk    - rising-edge clock
//            rst    - asynchronous active-high reset
//            start  - request, sampled only while idle
//            a, b   - minuend / subtrahend, captured on the accepting edge
//            busy   - high while bits are being processed
//            done   - one-cycle completion pulse
//            diff   - (a - b) mod 2^WIDTH, held until the next completion
//            borrow - 1 when a < b (unsigned), held with diff
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int                 CNT_W  = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]   c_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]   c_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_sa;
    logic [WIDTH-1:0]   r_sb;
    logic [WIDTH-1:0]   r_sd;
    logic               r_c;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_diff;
    logic               r_borrow;

    logic               w_s;
    logic               w_c_next;
    logic               w_nb;
    logic [WIDTH-1:0]   w_sd_next;

    // Full-adder cell: a + ~b + carry, with carry seeded to 1 on accept.
    assign w_nb     = ~r_sb[0];
    assign w_s      = r_sa[0] ^ w_nb ^ r_c;
    assign w_c_next = (r_sa[0] & w_nb) | (r_sa[0] & r_c) | (w_nb & r_c);

    // Result shift register: new sum bit enters at the MSB. A one-bit build
    // has nothing to shift, so the sum bit is the whole result.
    generate
        if (WIDTH == 1) begin : g_sd_single
            assign w_sd_next = w_s;
        end else begin : g_sd_multi
            assign w_sd_next = {w_s, r_sd[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_sa     <= '0;
            r_sb     <= '0;
            r_sd     <= '0;
            r_c      <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_sa    <= a;
                        r_sb    <= b;
                        r_sd    <= '0;
                        r_c     <= 1'b1;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_sa  <= r_sa >> 1;
                    r_sb  <= r_sb >> 1;
                    r_sd  <= w_sd_next;
                    r_c   <= w_c_next;
                    r_cnt <= r_cnt + c_ONE;
                    if (r_cnt == c_LAST) begin
                        // Final carry out of a + ~b + 1 is 1 exactly when a >= b.
                        r_diff   <= w_sd_next;
                        r_borrow <= ~w_c_next;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign diff   = r_diff;
    assign borrow = r_borrow;

endmodule
`default_nettype wire

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor built around a single full-adder cell plus a carry flip-flop, the inverse of the combinational full adder already in the design. It takes two WIDTH-bit operands with a start pulse, computes a − b one bit per clock (LSB first), and reports the WIDTH-bit difference and a borrow flag with a one-cycle done pulse. It is used where area matters more than latency, and as a sequential cross-check of the combinational adder path.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 1..32.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; sampled on the accepting edge only.
- b  input  WIDTH  subtrahend; sampled on the accepting edge only.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; high while in DONE.
- diff  output  WIDTH  result (a − b) mod 2^WIDTH; holds until the next completion.
- borrow  output  1  1 when a < b as unsigned; holds with diff.

## Operation
- Internal state: shift registers sa and sb (WIDTH each), result shift register sd (WIDTH), carry flip-flop c, bit counter cnt of ceil(log2(WIDTH+1)) bits, FSM.
- FSM states and transitions:
  - IDLE → RUN when start=1.
  - RUN → DONE after the WIDTH-th bit is processed.
  - DONE → IDLE unconditionally.
- Accept, edge in IDLE with start=1:
  - sa←a, sb←b, c←1 (the +1 of the two's-complement negation), cnt←0.
  - sd is cleared; diff and borrow are not touched.
- Each RUN edge:
  - Computes s = sa[0] ^ ~sb[0] ^ c and c_next = majority(sa[0], ~sb[0], c).
  - sa and sb shift right.
  - sd shifts right with s entering at the MSB.
  - c←c_next, cnt←cnt+1.
- On the RUN edge where cnt = WIDTH−1, in the same edge:
  - diff←final shifted sd value.
  - borrow←~c_next.
  - State→DONE.
- start is ignored in RUN and DONE. There is no queuing, and a and b changing mid-operation have no effect.
- Arithmetic is unsigned and modulo 2^WIDTH. For a = b, diff = 0 and borrow = 0.

## Timing
- Reset (asynchronous, immediate):
  - State→IDLE.
  - busy=0, done=0, diff=0, borrow=0.
  - sa, sb, sd, cnt cleared; c=0.
- Reset asserted mid-operation abandons the operation. No done pulse is produced, and outputs read zero.
- Latency:
  - Accepting edge N.
  - busy=1 during the cycles after edges N .. N+WIDTH−1.
  - diff, borrow and done update at edge N+WIDTH.
  - done=1 for exactly one cycle.
  - busy=0 from edge N+WIDTH.
- Throughput: the earliest next accept is edge N+WIDTH+2, i.e. one operation per WIDTH+2 cycles.
- start held high continuously gives back-to-back operations at that rate. a and b are re-sampled at each accepting edge.
- WIDTH=1: RUN lasts one cycle. DONE follows at edge N+1.

## Test plan
- Reset: assert rst asynchronously mid-cycle → busy, done, diff and borrow go to 0 immediately, with no clock edge required.
- Basic subtract (WIDTH=8): start with a=8'd20, b=8'd7 → done exactly 8 edges after the accept; diff=8'd13, borrow=0; busy high for exactly 8 cycles.
- Borrow and wrap (WIDTH=8):
  - a=8'd5, b=8'd9 → diff=8'hFC, borrow=1.
  - a=0, b=8'hFF → diff=8'h01, borrow=1.
- Equal operands and busy-ignore (WIDTH=8):
  - a=b=8'hA5 → diff=0, borrow=0.
  - Pulsing start and changing a/b during RUN must not alter the result or the timing.
- Back-to-back (WIDTH=8):
  - start held high with a=8'd100, b=8'd1, then a=8'd1, b=8'd2 → two done pulses 10 cycles apart.
  - Results are 8'd99 with borrow=0, then 8'hFF with borrow=1.
- Reset mid-operation, then WIDTH=1 exhaustive:
  - rst during RUN → no done pulse, diff=0; a fresh start afterwards runs normally.
  - WIDTH=1 build, all four a,b combinations → diff = a^b and borrow = ~a&b.
